// File: rtl/spi_master_tx.sv
// SPI initiator: mode 0, MSB first, SS active high, registered outputs.
// Define SPI_SS_ACTIVE_LOW_EN to make ss_out active low.
module spi_master_tx #(
    parameter int DATA_SIZE          = 8,
    parameter int HALF_PERIOD_CYCLES = 10,
    parameter int SS_SETUP_CYCLES    = 20,
    parameter int SS_HOLD_CYCLES     = 20
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] mosi_data,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_SIZE-1:0] miso_data,
    input  logic                 miso_in,
    output logic                 mosi_out,
    output logic                 sclk_out,
    output logic                 ss_out
);

`ifdef SPI_SS_ACTIVE_LOW_EN
    localparam logic SS_ON  = 1'b0;
    localparam logic SS_OFF = 1'b1;
`else
    localparam logic SS_ON  = 1'b1;
    localparam logic SS_OFF = 1'b0;
`endif

    localparam int CMAX_A = (SS_SETUP_CYCLES > SS_HOLD_CYCLES) ?
                            SS_SETUP_CYCLES : SS_HOLD_CYCLES;
    localparam int CMAX   = (CMAX_A > HALF_PERIOD_CYCLES) ?
                            CMAX_A : HALF_PERIOD_CYCLES;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int BW     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(SS_HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BIT_FIRST  = BW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_SIZE-1:0] tx_q, tx_d;
    logic [DATA_SIZE-1:0] rx_q, rx_d;
    logic [DATA_SIZE-1:0] miso_data_d;
    logic                 ss_d, sclk_d, mosi_d, busy_d, done_d;
    logic                 miso_meta, miso_s;

    // miso_in is asynchronous to sys_clk
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= miso_in;
            miso_s    <= miso_meta;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            miso_data <= '0;
            ss_out    <= SS_OFF;
            sclk_out  <= 1'b0;
            mosi_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            miso_data <= miso_data_d;
            ss_out    <= ss_d;
            sclk_out  <= sclk_d;
            mosi_out  <= mosi_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // outputs are computed for the next cycle and registered above
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        miso_data_d = miso_data;
        ss_d        = ss_out;
        sclk_d      = sclk_out;
        mosi_d      = mosi_out;
        busy_d      = busy;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = BIT_FIRST;
                    tx_d    = mosi_data;
                    rx_d    = '0;
                    ss_d    = SS_ON;
                    sclk_d  = 1'b0;
                    mosi_d  = mosi_data[DATA_SIZE-1];
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOW: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = rx_q << 1;
                    rx_d[0] = miso_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = LOW;
                        bit_d   = bit_q - BW'(1);
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_d[DATA_SIZE-1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    ss_d        = SS_OFF;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    miso_data_d = rx_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: vector table plus multi-cycle corner cases.
// Builds with or without SPI_SS_ACTIVE_LOW_EN.
module tb_spi_master_tx;

    localparam int DW   = 8;
    localparam int HALF = 10;

`ifdef SPI_SS_ACTIVE_LOW_EN
    localparam logic SS_ON  = 1'b0;
    localparam logic SS_OFF = 1'b1;
`else
    localparam logic SS_ON  = 1'b1;
    localparam logic SS_OFF = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] mosi_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] miso_data;
    logic          miso_in;
    logic          mosi_out;
    logic          sclk_out;
    logic          ss_out;

    spi_master_tx dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .start    (start),
        .mosi_data(mosi_data),
        .busy     (busy),
        .done     (done),
        .miso_data(miso_data),
        .miso_in  (miso_in),
        .mosi_out (mosi_out),
        .sclk_out (sclk_out),
        .ss_out   (ss_out)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // monitor and responder state, sampled on the falling sys_clk edge
    logic          ss_act;
    logic          ss_prev = 1'b0, sclk_prev = 1'b0, busy_prev = 1'b0;
    logic [DW-1:0] resp_word = '0;
    logic [DW-1:0] mosi_cap = '0;
    int            idx = DW - 1;
    int            ss_rise_c = 0, ss_fall_c = 0;
    int            busy_rise_c = 0, busy_fall_c = 0;
    int            rise_c = 0, fall_c = 0, first_rise_c = 0;
    int            rise_cnt = 0, txn_rises = 0;
    int            hi_bad = 0, lo_bad = 0, bad_edge = 0;
    int            done_cnt = 0, done_c = 0;

    assign ss_act  = (ss_out == SS_ON);
    assign miso_in = resp_word[idx];

    always @(negedge sys_clk) begin
        ss_prev   <= ss_act;
        sclk_prev <= sclk_out;
        busy_prev <= busy;
        if (ss_act && !ss_prev) begin
            ss_rise_c <= cyc;
            txn_rises <= 0;
        end
        if (!ss_act && ss_prev) ss_fall_c <= cyc;
        if (busy && !busy_prev) busy_rise_c <= cyc;
        if (!busy && busy_prev) busy_fall_c <= cyc;
        if (sclk_out && !sclk_prev) begin
            rise_cnt  <= rise_cnt + 1;
            txn_rises <= txn_rises + 1;
            rise_c    <= cyc;
            mosi_cap  <= {mosi_cap[DW-2:0], mosi_out};
            if (txn_rises == 0) first_rise_c <= cyc;
            else if (cyc - fall_c != HALF) lo_bad <= lo_bad + 1;
            if (!ss_act) bad_edge <= bad_edge + 1;
        end
        if (!sclk_out && sclk_prev) begin
            fall_c <= cyc;
            if (cyc - rise_c != HALF) hi_bad <= hi_bad + 1;
            if (!ss_act) bad_edge <= bad_edge + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_c   <= cyc;
        end
        if (!ss_act) idx <= DW - 1;
        else if (!sclk_out && sclk_prev && idx > 0) idx <= idx - 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic start_txn(input logic [DW-1:0] tx, input logic [DW-1:0] rx);
        resp_word = rx;
        mosi_data = tx;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != base) break;
            tick();
        end
        check(name, 32'(done_cnt != base), 32'd1);
    endtask

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        logic [DW-1:0] exp_mosi;
        logic [DW-1:0] exp_miso;
    } vec_t;

    vec_t vecs[4];
    int   rise_b, hi_b, lo_b, bad_b, done_b, fall1, done1, k;

    initial begin
        vecs[0] = '{tx: 8'he7, rx: 8'h3a, exp_mosi: 8'he7, exp_miso: 8'h3a};
        vecs[1] = '{tx: 8'h01, rx: 8'h80, exp_mosi: 8'h01, exp_miso: 8'h80};
        vecs[2] = '{tx: 8'haa, rx: 8'h55, exp_mosi: 8'haa, exp_miso: 8'h55};
        vecs[3] = '{tx: 8'h00, rx: 8'hff, exp_mosi: 8'h00, exp_miso: 8'hff};

        rst       = 1'b1;
        start     = 1'b0;
        mosi_data = '0;
        repeat (3) tick();
        check("rst_ss", 32'(ss_out), 32'(SS_OFF));
        check("rst_sclk", 32'(sclk_out), 32'd0);
        check("rst_mosi", 32'(mosi_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_miso_data", 32'(miso_data), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_ss", 32'(ss_out), 32'(SS_OFF));

        foreach (vecs[i]) begin
            rise_b = rise_cnt;
            hi_b   = hi_bad;
            lo_b   = lo_bad;
            bad_b  = bad_edge;
            done_b = done_cnt;
            start_txn(vecs[i].tx, vecs[i].rx);
            check("busy_at_k", 32'(busy), 32'd1);
            check("ss_at_k", 32'(ss_out), 32'(SS_ON));
            check("mosi_at_k", 32'(mosi_out), 32'(vecs[i].tx[DW-1]));
            wait_done("done_seen");
            check("miso_data", 32'(miso_data), 32'(vecs[i].exp_miso));
            check("mosi_bits", 32'(mosi_cap), 32'(vecs[i].exp_mosi));
            check("sclk_rises", 32'(rise_cnt - rise_b), 32'(DW));
            check("done_lat", 32'(done_c - ss_rise_c), 32'd200);
            check("ss_to_sclk", 32'(first_rise_c - ss_rise_c), 32'd30);
            check("sclk_to_ssfall", 32'(ss_fall_c - fall_c), 32'd20);
            check("ssfall_eq_done", 32'(ss_fall_c - done_c), 32'd0);
            check("busy_len", 32'(busy_fall_c - busy_rise_c), 32'd200);
            check("busy_start", 32'(busy_rise_c - ss_rise_c), 32'd0);
            check("phase_hi", 32'(hi_bad - hi_b), 32'd0);
            check("phase_lo", 32'(lo_bad - lo_b), 32'd0);
            check("edge_no_ss", 32'(bad_edge - bad_b), 32'd0);
            tick();
            check("done_pulse", 32'(done_cnt - done_b), 32'd1);
            check("done_low", 32'(done), 32'd0);
            repeat (10) tick();
        end

        // back-to-back with start held high
        resp_word = 8'h29;
        mosi_data = 8'hf1;
        start     = 1'b1;
        wait_done("b2b_done1");
        fall1     = ss_fall_c;
        done1     = done_c;
        check("b2b_miso1", 32'(miso_data), 32'h29);
        check("b2b_mosi1", 32'(mosi_cap), 32'hf1);
        mosi_data = 8'h29;
        resp_word = 8'he7;
        tick();
        check("b2b_ss_gap", 32'(ss_rise_c - fall1), 32'd1);
        wait_done("b2b_done2");
        start = 1'b0;
        check("b2b_spacing", 32'(done_c - done1), 32'd201);
        check("b2b_miso2", 32'(miso_data), 32'he7);
        check("b2b_mosi2", 32'(mosi_cap), 32'h29);
        repeat (10) tick();
        check("b2b_stopped", 32'(busy), 32'd0);

        // start while busy is ignored
        done_b = done_cnt;
        start_txn(8'he7, 8'h3a);
        k = ss_rise_c;
        while (cyc < k + 50) tick();
        mosi_data = 8'h18;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done("ign_done");
        check("ign_mosi", 32'(mosi_cap), 32'he7);
        check("ign_miso", 32'(miso_data), 32'h3a);
        check("ign_lat", 32'(done_c - k), 32'd200);
        repeat (30) tick();
        check("ign_one_done", 32'(done_cnt - done_b), 32'd1);
        check("ign_idle", 32'(busy), 32'd0);

        // reset mid-transfer
        done_b = done_cnt;
        start_txn(8'hc3, 8'h5a);
        k = ss_rise_c;
        while (cyc < k + 95) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ss", 32'(ss_out), 32'(SS_OFF));
        check("mid_rst_sclk", 32'(sclk_out), 32'd0);
        check("mid_rst_mosi", 32'(mosi_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_miso_data", 32'(miso_data), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (250) tick();
        check("rst_no_done", 32'(done_cnt - done_b), 32'd0);
        check("rst_miso_hold", 32'(miso_data), 32'd0);
        start_txn(8'h96, 8'hc5);
        wait_done("post_rst_done");
        check("post_rst_miso", 32'(miso_data), 32'hc5);
        check("post_rst_mosi", 32'(mosi_cap), 32'h96);
        check("post_rst_lat", 32'(done_c - ss_rise_c), 32'd200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
